// File: rtl/trivium_ctrl.sv
// trivium_ctrl: loads key/IV bytes into the Trivium core, runs warm-up, then packs keystream bits into bytes.
module trivium_ctrl #(
    parameter int KEY_BYTES = 10,
    parameter int IV_BYTES  = 10,
    parameter int WARMUP    = 1152
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cmd_start,
    input  logic       cmd_stop,
    input  logic       in_valid,
    input  logic [7:0] in_data,
    output logic       in_ready,
    output logic       core_wr_en,
    output logic [4:0] core_wr_addr,
    output logic [7:0] core_wr_data,
    output logic       core_load,
    output logic       core_step,
    input  logic       core_ks_bit,
    output logic       ks_valid,
    output logic [7:0] ks_data,
    input  logic       ks_ready,
    output logic       busy,
    output logic [2:0] state
);
    localparam logic [2:0] S_IDLE = 3'd0, S_LOAD = 3'd1, S_INIT = 3'd2, S_WARM = 3'd3, S_GEN = 3'd4;
    localparam logic [4:0] LAST_BYTE = 5'(KEY_BYTES + IV_BYTES - 1);
    localparam logic [10:0] LAST_WARM = 11'(WARMUP - 1);

    logic [2:0]  r_state, w_next;
    logic [4:0]  r_byte_cnt;
    logic [10:0] r_warm_cnt;
    logic [2:0]  r_bit_cnt;
    logic        r_ks_valid;
    logic [7:0]  r_ks_data;
    logic [7:0]  r_ks_shift;
    logic        w_accept;
    logic        w_gen_step;

    assign w_accept   = r_state == S_LOAD && in_valid && !cmd_stop;
    // Stall only when finishing a byte would overwrite one not yet consumed.
    assign w_gen_step = r_state == S_GEN && !cmd_stop && !cmd_start &&
                        !(r_bit_cnt == 3'd7 && r_ks_valid && !ks_ready);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        if (cmd_stop) w_next = S_IDLE;
        else begin
            case (r_state)
                S_IDLE:  w_next = cmd_start ? S_LOAD : S_IDLE;
                S_LOAD:  w_next = (w_accept && r_byte_cnt == LAST_BYTE) ? S_INIT : S_LOAD;
                S_INIT:  w_next = S_WARM;
                S_WARM:  w_next = (r_warm_cnt == LAST_WARM) ? S_GEN : S_WARM;
                S_GEN:   w_next = cmd_start ? S_LOAD : S_GEN;
                default: w_next = S_IDLE;
            endcase
        end
    end

    always_comb begin
        in_ready     = r_state == S_LOAD;
        core_wr_en   = w_accept;
        core_wr_addr = in_ready ? r_byte_cnt : 5'd0;
        core_wr_data = in_ready ? in_data : 8'd0;
        core_load    = r_state == S_INIT && !cmd_stop;
        core_step    = (r_state == S_WARM && !cmd_stop) || w_gen_step;
        ks_valid     = r_ks_valid;
        ks_data      = r_ks_data;
        busy         = r_state != S_IDLE;
        state        = r_state;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_byte_cnt <= '0;
            r_warm_cnt <= '0;
            r_bit_cnt  <= '0;
            r_ks_valid <= 1'b0;
            r_ks_data  <= '0;
            r_ks_shift <= '0;
        end else if (cmd_stop) begin
            r_byte_cnt <= '0;
            r_warm_cnt <= '0;
            r_bit_cnt  <= '0;
            r_ks_valid <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: r_byte_cnt <= '0;
                S_LOAD: begin
                    if (w_accept) r_byte_cnt <= r_byte_cnt + 5'd1;
                    r_warm_cnt <= '0;
                end
                S_INIT: r_warm_cnt <= '0;
                S_WARM: begin
                    r_warm_cnt <= r_warm_cnt + 11'd1;
                    r_bit_cnt  <= '0;
                end
                S_GEN: begin
                    if (cmd_start) begin
                        r_byte_cnt <= '0;
                        r_bit_cnt  <= '0;
                        r_ks_valid <= 1'b0;
                    end else begin
                        if (w_gen_step) begin
                            r_ks_shift[r_bit_cnt] <= core_ks_bit;
                            r_bit_cnt <= r_bit_cnt + 3'd1;
                        end
                        if (w_gen_step && r_bit_cnt == 3'd7) begin
                            r_ks_data  <= {core_ks_bit, r_ks_shift[6:0]};
                            r_ks_valid <= 1'b1;
                        end else if (r_ks_valid && ks_ready) begin
                            r_ks_valid <= 1'b0;
                        end
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_trivium_ctrl.sv
// tb_trivium_ctrl: directed checks of load, warm-up timing, byte packing, backpressure, abort and rekey.
module tb_trivium_ctrl;
    logic       clk = 1'b0;
    logic       rst_n, cmd_start, cmd_stop, in_valid, ks_ready;
    logic [7:0] in_data;
    logic       in_ready, core_wr_en, core_load, core_step, ks_valid, busy;
    logic [4:0] core_wr_addr;
    logic [7:0] core_wr_data, ks_data;
    logic [2:0] state;
    logic       core_ks_bit;

    int total = 0, bad = 0;
    int step_cnt = 0, load_cnt = 0, wr_cnt = 0, gen_steps = 0;
    int s0, w0, n;

    // Stub core: first GEN byte bits 1,0,1,1,0,0,0,0 (0x0D), second byte 0xA5, LSB first.
    logic [15:0] pat = 16'hA50D;
    assign core_ks_bit = pat[gen_steps[3:0]];

    trivium_ctrl dut (
        .clk(clk), .rst_n(rst_n), .cmd_start(cmd_start), .cmd_stop(cmd_stop),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .core_wr_en(core_wr_en), .core_wr_addr(core_wr_addr), .core_wr_data(core_wr_data),
        .core_load(core_load), .core_step(core_step), .core_ks_bit(core_ks_bit),
        .ks_valid(ks_valid), .ks_data(ks_data), .ks_ready(ks_ready),
        .busy(busy), .state(state)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        step_cnt  <= step_cnt + int'(core_step);
        load_cnt  <= load_cnt + int'(core_load);
        wr_cnt    <= wr_cnt + int'(core_wr_en);
        gen_steps <= (state == 3'd4) ? gen_steps + int'(core_step) : 0;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst_n = 1'b0; cmd_start = 1'b0; cmd_stop = 1'b0;
        in_valid = 1'b1; in_data = 8'hFF; ks_ready = 1'b0;
        #2;
        chk("rst_in_ready", 32'(in_ready), 0);
        chk("rst_wr_en", 32'(core_wr_en), 0);
        chk("rst_wr_addr", 32'(core_wr_addr), 0);
        chk("rst_wr_data", 32'(core_wr_data), 0);
        chk("rst_load", 32'(core_load), 0);
        chk("rst_step", 32'(core_step), 0);
        chk("rst_ks_valid", 32'(ks_valid), 0);
        chk("rst_ks_data", 32'(ks_data), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_state", 32'(state), 0);
        @(negedge clk); rst_n = 1'b1; in_valid = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk); #1;
            chk("idle_in_ready", 32'(in_ready), 0);
            chk("idle_state", 32'(state), 0);
        end
        // Contiguous load of 0x00..0x13
        @(negedge clk); cmd_start = 1'b1;
        @(negedge clk); cmd_start = 1'b0;
        for (int i = 0; i < 20; i++) begin
            in_valid = 1'b1; in_data = 8'(i); #1;
            chk("load_wr_en", 32'(core_wr_en), 1);
            chk("load_addr", 32'(core_wr_addr), 32'(i));
            chk("load_data", 32'(core_wr_data), 32'(i));
            @(negedge clk);
        end
        in_valid = 1'b0; #1;
        chk("init_load", 32'(core_load), 1);
        chk("init_state", 32'(state), 2);
        s0 = step_cnt;
        @(negedge clk); #1;
        chk("warm_load_low", 32'(core_load), 0);
        chk("warm_state", 32'(state), 3);
        repeat (1151) @(negedge clk);
        #1 chk("warm_last_state", 32'(state), 3);
        @(negedge clk); #1;
        chk("gen_state", 32'(state), 4);
        chk("warm_steps", 32'(step_cnt - s0), 1152);
        chk("load_once", 32'(load_cnt), 1);
        chk("wr_total", 32'(wr_cnt), 20);
        repeat (7) @(negedge clk);
        #1 chk("ks_valid_early", 32'(ks_valid), 0);
        @(negedge clk); #1;
        chk("ks_valid_first", 32'(ks_valid), 1);
        chk("ks_data_first", 32'(ks_data), 32'h0D);
        // Backpressure on second byte
        repeat (7) @(negedge clk);
        #1;
        chk("bp_stall", 32'(core_step), 0);
        chk("bp_hold_data", 32'(ks_data), 32'h0D);
        chk("bp_hold_valid", 32'(ks_valid), 1);
        @(negedge clk); #1;
        chk("bp_stall2", 32'(core_step), 0);
        ks_ready = 1'b1; #1;
        chk("bp_resume", 32'(core_step), 1);
        @(negedge clk); #1;
        chk("bp_byte2", 32'(ks_data), 32'hA5);
        chk("bp_valid2", 32'(ks_valid), 1);
        chk("bp_steps16", 32'(gen_steps), 16);
        // Rekey from GEN with a byte pending
        ks_ready = 1'b0; cmd_start = 1'b1; #1;
        chk("rekey_no_step", 32'(core_step), 0);
        @(negedge clk); cmd_start = 1'b0; #1;
        chk("rekey_state", 32'(state), 1);
        chk("rekey_ks_valid", 32'(ks_valid), 0);
        chk("rekey_addr", 32'(core_wr_addr), 0);
        // Gapped load with an ignored start after 5 bytes
        w0 = wr_cnt; n = 0;
        for (int k = 0; k < 40 && n < 20; k++) begin
            in_valid = (k % 2 == 0);
            in_data = 8'(8'h40 + n);
            cmd_start = (n == 5) && in_valid;
            #1;
            if (in_valid) begin
                chk("gap_addr", 32'(core_wr_addr), 32'(n));
                chk("gap_data", 32'(core_wr_data), 32'(8'h40 + n));
                n++;
            end else chk("gap_idle_wr", 32'(core_wr_en), 0);
            @(negedge clk);
        end
        in_valid = 1'b0; cmd_start = 1'b0; #1;
        chk("gap_load", 32'(core_load), 1);
        chk("gap_wr_total", 32'(wr_cnt - w0), 20);
        // Abort during warm-up
        @(negedge clk);
        s0 = step_cnt;
        repeat (500) @(negedge clk);
        cmd_stop = 1'b1; #1;
        chk("stop_no_step", 32'(core_step), 0);
        chk("stop_steps", 32'(step_cnt - s0), 500);
        @(negedge clk); cmd_stop = 1'b0; #1;
        chk("stop_state", 32'(state), 0);
        chk("stop_busy", 32'(busy), 0);
        repeat (10) @(negedge clk);
        #1 chk("stop_quiet", 32'(step_cnt - s0), 500);
        // Async reset mid-load
        cmd_start = 1'b1;
        @(negedge clk); cmd_start = 1'b0; in_valid = 1'b1; in_data = 8'h77;
        @(negedge clk); @(negedge clk);
        #1 chk("mid_addr", 32'(core_wr_addr), 2);
        #1 rst_n = 1'b0; #1;
        chk("mid_rst_state", 32'(state), 0);
        chk("mid_rst_wr_en", 32'(core_wr_en), 0);
        @(negedge clk); rst_n = 1'b1; in_valid = 1'b0;
        cmd_start = 1'b1;
        @(negedge clk); cmd_start = 1'b0; in_valid = 1'b1; #1;
        chk("restart_addr", 32'(core_wr_addr), 0);
        @(negedge clk); in_valid = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/trivium_ctrl.md
Name: trivium_ctrl

Overview:
Sequencer for the Trivium keystream core in the tt10-trivium design. It accepts the 80-bit key and 80-bit IV as a byte stream on a valid/ready handshake and writes each byte into the core's staging registers. It then pulses the core load, runs the fixed warm-up rounds, and steps the core to assemble keystream bits into bytes for a downstream consumer with backpressure.

Parameters:
KEY_BYTES, 10, key bytes accepted before the IV bytes.
IV_BYTES, 10, IV bytes accepted after the key bytes.
WARMUP, 1152, core steps with output discarded (4 x 288).

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
cmd_start  in  1  begin (re)keying; sampled in IDLE and GEN only
cmd_stop  in  1  synchronous abort to IDLE from any state
in_valid  in  1  key/IV byte valid
in_data  in  8  key/IV byte
in_ready  out  1  controller accepts a byte
core_wr_en  out  1  write in_data to core staging register
core_wr_addr  out  5  staging byte index: 0..9 key, 10..19 IV
core_wr_data  out  8  byte to write (= in_data)
core_load  out  1  one-cycle pulse: core loads its state from staging
core_step  out  1  core advances one round this cycle
core_ks_bit  in  1  core keystream bit for the current step
ks_valid  out  1  ks_data valid
ks_data  out  8  keystream byte
ks_ready  in  1  consumer accepts ks_data
busy  out  1  state != IDLE
state  out  3  IDLE=0, LOAD=1, INIT=2, WARM=3, GEN=4

Behaviour:
- Reset (async assert on rst_n low): state IDLE, byte_cnt=0, warm_cnt=0, bit_cnt=0, ks_valid=0, ks_data=0, ks_shift=0. All outputs are low while reset is held.
- Counters: byte_cnt is 5 bits, warm_cnt is 11 bits, bit_cnt is 3 bits.
- IDLE: in_ready=0, core_step=0. On cmd_start, go to LOAD with byte_cnt=0.
- LOAD:
  - in_ready=1.
  - A byte is accepted when in_valid & in_ready.
  - core_wr_en = accept. It is combinational in the same cycle, with core_wr_addr=byte_cnt and core_wr_data=in_data.
  - byte_cnt increments on each accept.
  - On the accept where byte_cnt = KEY_BYTES+IV_BYTES-1, go to INIT.
- INIT: core_load=1 for exactly one cycle. Next state is WARM with warm_cnt=0.
- WARM:
  - core_step=1 every cycle and core_ks_bit is ignored.
  - warm_cnt increments each cycle.
  - When warm_cnt = WARMUP-1, go to GEN with bit_cnt=0. This gives exactly WARMUP steps.
- GEN stepping:
  - core_step = !(bit_cnt==7 && ks_valid && !ks_ready). The core stalls only when completing a byte would overwrite an unconsumed ks_data.
  - On each step, ks_shift[bit_cnt] = core_ks_bit and bit_cnt increments (wraps 7 to 0).
  - Bit order is LSB first: the first generated bit of a byte goes to ks_data[0].
- GEN byte output:
  - On the step with bit_cnt=7: ks_data takes {core_ks_bit, ks_shift[6:0]} and ks_valid=1 (registered).
  - Otherwise ks_valid clears on ks_valid & ks_ready.
  - Simultaneous ready and new byte completion: the new byte is loaded and ks_valid stays 1.
- Latency: if the last IV byte is accepted at cycle T:
  - core_load is high at T+1.
  - Warm-up steps occur at T+2..T+1153.
  - GEN steps occur from T+1154.
  - ks_valid first rises at T+1162.
- cmd_start in GEN:
  - Go to LOAD with byte_cnt=0.
  - ks_valid clears, bit_cnt clears, and no step occurs that cycle.
- cmd_start in LOAD, INIT or WARM: ignored.
- cmd_stop in any state:
  - Next state is IDLE and all counters clear.
  - ks_valid clears and no core_wr_en, core_load or core_step is issued that cycle.
  - cmd_stop has priority over cmd_start and over an in-flight byte accept.
- Reset mid-operation: immediate return to reset values. The core contents are not required to be cleared.

Test Plan:
- Reset/idle: hold rst_n=0 with in_valid=1 -> all outputs 0. After release with no cmd_start -> in_ready=0 and state=0 for 20 cycles.
- Load, then warm-up/first byte:
  - Stimulus: cmd_start, then 20 bytes 0x00..0x13 with in_valid held.
  - Writes: core_wr_en is high 20 cycles, addresses 0..19, data 0x00..0x13.
  - core_load is high exactly once, one cycle after the last byte.
  - Warm-up: exactly 1152 core_step cycles before GEN.
  - First byte: stub core_ks_bit sequence 1,0,1,1,0,0,0,0 in GEN -> ks_data=0x0D with ks_valid at T+1162.
- Load gaps: toggle in_valid every other cycle -> byte_cnt advances only on accepts, addresses remain contiguous 0..19, and core_load timing is relative to the 20th accept.
- Backpressure:
  - ks_ready=0 in GEN -> after the 2nd byte's 7 bits, core_step=0 and ks_data holds byte 1.
  - Raise ks_ready -> byte 1 consumed, step resumes, byte 2 loads in that cycle, no bits lost (count 16 steps per 2 bytes).
- Abort/rekey:
  - cmd_stop at WARM step 500 -> IDLE the next cycle, no further core_step.
  - cmd_start in GEN with ks_valid=1 -> ks_valid=0 and state=LOAD, byte_cnt=0.
- Ignored start: cmd_start pulsed in LOAD after 5 bytes -> byte_cnt continues from 5 and total writes = 20.
